// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline control bundle between the datapath and the hazard controller.
// master = datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       id_opCode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_memRead;
    logic [4:0]       ex_rt;
    logic             ex_branch;
    logic             ex_zero;
    logic             mem_memRead;
    logic             mem_memWrite;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_write;
    logic             pc_src;
    logic             dmem_req;
    logic             hz_error;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_opCode, id_rs, id_rt,
        output ex_memRead, ex_rt, ex_branch, ex_zero,
        output mem_memRead, mem_memWrite, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
        input  pipe_write, pc_src, dmem_req, hz_error, stall_count
    );

    modport slave (
        input  id_opCode, id_rs, id_rt,
        input  ex_memRead, ex_rt, ex_branch, ex_zero,
        input  mem_memRead, mem_memWrite, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
        output pipe_write, pc_src, dmem_req, hz_error, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / freeze sequencer for a 5-stage MIPS pipeline.
// Load-use bubbles, taken-branch flush, dmem freeze and wait timeout.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t           state, state_n;
    logic [WC_W-1:0]  wait_cnt, wait_n;
    logic [CNT_W-1:0] stall_q;
    logic             err_q, err_n;
    logic             stall_inc;

    logic mem_acc, freeze, uses_rt, load_use, take_br;

    always_comb begin
        uses_rt = 1'b0;
        case (bus.id_opCode)
            6'h00, 6'h04, 6'h2B: uses_rt = 1'b1;
            default:             uses_rt = 1'b0;
        endcase
    end

    assign mem_acc  = bus.mem_memRead | bus.mem_memWrite;
    assign freeze   = mem_acc & ~bus.dmem_ready;
    assign take_br  = bus.ex_branch & bus.ex_zero;
    assign load_use = bus.ex_memRead & (bus.ex_rt != 5'd0)
                    & ((bus.ex_rt == bus.id_rs)
                    | (uses_rt & (bus.ex_rt == bus.id_rt)));

    always_comb begin
        state_n          = state;
        wait_n           = wait_cnt;
        err_n            = err_q;
        stall_inc        = 1'b0;
        bus.pc_write     = 1'b0;
        bus.ifid_write   = 1'b0;
        bus.ifid_flush   = 1'b0;
        bus.idex_bubble  = 1'b0;
        bus.pipe_write   = 1'b0;
        bus.pc_src       = 1'b0;
        bus.dmem_req     = reset & mem_acc & (state != ERROR);
        if (!reset || state == ERROR) begin
            // outputs stay low; ERROR is left only through reset
        end else if (freeze) begin
            if (state == RUN) begin
                state_n = MEM_WAIT;
                wait_n  = WC_W'(1);
            end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                state_n = ERROR;
                err_n   = 1'b1;
            end else begin
                wait_n = wait_cnt + 1'b1;
            end
        end else begin
            state_n        = RUN;
            wait_n         = '0;
            bus.pipe_write = 1'b1;
            if (take_br) begin
                bus.pc_write    = 1'b1;
                bus.ifid_write  = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
                bus.pc_src      = 1'b1;
            end else if (load_use) begin
                bus.idex_bubble = 1'b1;
                stall_inc       = 1'b1;
            end else begin
                bus.pc_write   = 1'b1;
                bus.ifid_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            err_q    <= err_n;
            if (stall_inc && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.hz_error    = err_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=2).
// Output vector order: pc_write ifid_write ifid_flush idex_bubble pipe_write pc_src dmem_req.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 2;

    localparam logic [6:0] O_ZERO  = 7'b0000000;
    localparam logic [6:0] O_NORM  = 7'b1100100;
    localparam logic [6:0] O_STALL = 7'b0001100;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_FRZ   = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_bubble, bus.pipe_write, bus.pc_src,
                bus.dmem_req};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.id_opCode    = 6'h00;
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.ex_memRead   = 1'b0;
        bus.ex_rt        = 5'd0;
        bus.ex_branch    = 1'b0;
        bus.ex_zero      = 1'b0;
        bus.mem_memRead  = 1'b0;
        bus.mem_memWrite = 1'b0;
        bus.dmem_ready   = 1'b0;
    endtask

    task automatic lw_use(input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] ert);
        idle();
        bus.ex_memRead = 1'b1;
        bus.ex_rt      = ert;
        bus.id_opCode  = op;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held with hazardous inputs: everything must be low
        lw_use(6'h00, 5'd8, 5'd0, 5'd8);
        bus.mem_memRead = 1'b1;
        #1;
        chk("rst_outs", 32'(outs()), 32'(O_ZERO));
        chk("rst_stall", 32'(bus.stall_count), 0);
        chk("rst_err", 32'(bus.hz_error), 0);

        @(negedge clk); reset = 1'b1; idle(); #1;
        chk("normal_outs", 32'(outs()), 32'(O_NORM));
        edge_wait();
        chk("normal_stall", 32'(bus.stall_count), 0);

        // lw $t0 ; add rs=$t0
        @(negedge clk); lw_use(6'h00, 5'd8, 5'd1, 5'd8); #1;
        chk("lu_add_outs", 32'(outs()), 32'(O_STALL));
        edge_wait();
        chk("lu_add_cnt", 32'(bus.stall_count), 1);

        // addi rt=8 rs=9 does not read rt
        @(negedge clk); lw_use(6'h08, 5'd9, 5'd8, 5'd8); #1;
        chk("lu_addi_outs", 32'(outs()), 32'(O_NORM));
        edge_wait();
        chk("lu_addi_cnt", 32'(bus.stall_count), 1);

        // sw reads rt
        @(negedge clk); lw_use(6'h2B, 5'd9, 5'd8, 5'd8); #1;
        chk("lu_sw_outs", 32'(outs()), 32'(O_STALL));
        edge_wait();
        chk("lu_sw_cnt", 32'(bus.stall_count), 2);

        // load into $zero never stalls
        @(negedge clk); lw_use(6'h00, 5'd0, 5'd0, 5'd0); #1;
        chk("lu_zero_outs", 32'(outs()), 32'(O_NORM));
        edge_wait();
        chk("lu_zero_cnt", 32'(bus.stall_count), 2);

        // freeze 3 cycles with load-use pending, ready on 4th
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lw_use(6'h00, 5'd8, 5'd1, 5'd8);
            bus.mem_memRead = 1'b1; #1;
            chk("frz_outs", 32'(outs()), 32'(O_FRZ));
            edge_wait();
            chk("frz_cnt", 32'(bus.stall_count), 2);
            chk("frz_err", 32'(bus.hz_error), 0);
        end
        @(negedge clk); bus.dmem_ready = 1'b1; #1;
        chk("frz_rel_outs", 32'(outs()), 32'({O_STALL[6:1], 1'b1}));
        edge_wait();
        chk("frz_rel_cnt", 32'(bus.stall_count), 3);

        // taken branch wins over load-use, not counted
        @(negedge clk); lw_use(6'h00, 5'd8, 5'd1, 5'd8);
        bus.ex_branch = 1'b1; bus.ex_zero = 1'b1; #1;
        chk("br_outs", 32'(outs()), 32'(O_BR));
        edge_wait();
        chk("br_cnt", 32'(bus.stall_count), 3);

        // branch not taken
        @(negedge clk); idle(); bus.ex_branch = 1'b1; #1;
        chk("br_nt_outs", 32'(outs()), 32'(O_NORM));

        // counter saturates at 3
        @(negedge clk); lw_use(6'h04, 5'd2, 5'd8, 5'd8); #1;
        chk("sat_outs", 32'(outs()), 32'(O_STALL));
        edge_wait();
        chk("sat_cnt", 32'(bus.stall_count), 3);

        // timeout: ERROR after TO frozen cycles
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk); idle(); bus.mem_memWrite = 1'b1; #1;
            chk("to_outs", 32'(outs()), 32'(O_FRZ));
            edge_wait();
            chk("to_err", 32'(bus.hz_error), (i == TO) ? 1 : 0);
        end
        @(negedge clk); bus.dmem_ready = 1'b1; #1;
        chk("err_outs", 32'(outs()), 32'(O_ZERO));
        edge_wait();
        chk("err_sticky", 32'(bus.hz_error), 1);

        @(negedge clk); reset = 1'b0; #1;
        chk("err_rst", 32'(bus.hz_error), 0);
        chk("err_rst_cnt", 32'(bus.stall_count), 0);

        @(negedge clk); reset = 1'b1; lw_use(6'h00, 5'd8, 5'd1, 5'd8);
        edge_wait();
        chk("pre_cnt", 32'(bus.stall_count), 1);

        // reset pulsed in the middle of MEM_WAIT
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); bus.mem_memRead = 1'b1;
            edge_wait();
        end
        @(negedge clk); reset = 1'b0; #1;
        chk("mid_outs", 32'(outs()), 32'(O_ZERO));
        chk("mid_cnt", 32'(bus.stall_count), 0);
        chk("mid_err", 32'(bus.hz_error), 0);

        @(negedge clk); reset = 1'b1; idle(); #1;
        chk("post_outs", 32'(outs()), 32'(O_NORM));
        edge_wait();

        // fresh wait of TO-1 cycles must not time out
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk); idle(); bus.mem_memWrite = 1'b1; #1;
            chk("post_frz", 32'(outs()), 32'(O_FRZ));
            edge_wait();
            chk("post_err", 32'(bus.hz_error), 0);
        end
        @(negedge clk); bus.dmem_ready = 1'b1; #1;
        chk("post_rel", 32'(outs()), 32'({O_NORM[6:1], 1'b1}));
        edge_wait();
        chk("post_rel_err", 32'(bus.hz_error), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
